// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI-lite arbiter: FSM state encoding and
// response codes.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A request counts as a write as soon as either write channel is valid.
  function automatic logic is_write(input logic awvalid, input logic wvalid);
    return awvalid | wvalid;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle (AR, R, AW, W, B channels). The master modport is the
// requester side, the slave modport is the responder side.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, input  arready,
    input  rvalid, rdata, rresp, output rready,
    output awvalid, awaddr, input  awready,
    output wvalid, wdata, wstrb, input  wready,
    input  bvalid, bresp, output bready
  );

  modport slave (
    input  arvalid, araddr, output arready,
    output rvalid, rdata, rresp, input  rready,
    input  awvalid, awaddr, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input  bready
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not served
// last wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch can be inferred.
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) gnt_idx = ~last;
    else              gnt_idx = req[1];
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-lite slave between two masters, one transaction at a time,
// with round-robin grant. Channel muxing is combinational on registered state.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] req;
  logic       gnt_valid, gnt_idx, nxt_write;
  logic       aw_fire, w_fire;

  // Granted master's inbound signals.
  logic                g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  logic [ADDR_W-1:0]   g_araddr, g_awaddr;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;

  // Signals headed back to the granted master.
  logic                g_arready, g_rvalid, g_awready, g_wready, g_bvalid;
  logic [DATA_W-1:0]   g_rdata;
  logic [1:0]          g_rresp, g_bresp;

  assign req = {m1.arvalid | m1.awvalid | m1.wvalid,
                m0.arvalid | m0.awvalid | m0.wvalid};

  rr_arb2 u_rr (
    .req       (req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign nxt_write = gnt_idx ? is_write(m1.awvalid, m1.wvalid)
                             : is_write(m0.awvalid, m0.wvalid);

  assign g_arvalid = grant_q ? m1.arvalid : m0.arvalid;
  assign g_araddr  = grant_q ? m1.araddr  : m0.araddr;
  assign g_rready  = grant_q ? m1.rready  : m0.rready;
  assign g_awvalid = grant_q ? m1.awvalid : m0.awvalid;
  assign g_awaddr  = grant_q ? m1.awaddr  : m0.awaddr;
  assign g_wvalid  = grant_q ? m1.wvalid  : m0.wvalid;
  assign g_wdata   = grant_q ? m1.wdata   : m0.wdata;
  assign g_wstrb   = grant_q ? m1.wstrb   : m0.wstrb;
  assign g_bready  = grant_q ? m1.bready  : m0.bready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;

    s.arvalid = 1'b0;
    s.araddr  = '0;
    s.rready  = 1'b0;
    s.awvalid = 1'b0;
    s.awaddr  = '0;
    s.wvalid  = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.bready  = 1'b0;

    g_arready = 1'b0;
    g_rvalid  = 1'b0;
    g_rdata   = '0;
    g_rresp   = '0;
    g_awready = 1'b0;
    g_wready  = 1'b0;
    g_bvalid  = 1'b0;
    g_bresp   = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d = gnt_idx;
          state_d = nxt_write ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        s.arvalid = g_arvalid;
        s.araddr  = g_araddr;
        g_arready = s.arready;
        if (g_arvalid && s.arready) state_d = RD_D;
      end
      RD_D: begin
        g_rvalid = s.rvalid;
        g_rdata  = s.rdata;
        g_rresp  = s.rresp;
        s.rready = g_rready;
        if (s.rvalid && g_rready) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      WR_AW: begin
        // Each channel closes independently once it has handshaken.
        s.awvalid = g_awvalid & ~aw_done_q;
        s.awaddr  = g_awaddr;
        g_awready = s.awready & ~aw_done_q;
        s.wvalid  = g_wvalid & ~w_done_q;
        s.wdata   = g_wdata;
        s.wstrb   = g_wstrb;
        g_wready  = s.wready & ~w_done_q;
        aw_fire   = g_awvalid & ~aw_done_q & s.awready;
        w_fire    = g_wvalid & ~w_done_q & s.wready;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_B: begin
        g_bvalid = s.bvalid;
        g_bresp  = s.bresp;
        s.bready = g_bready;
        if (s.bvalid && g_bready) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The non-granted master sees all-zero outputs.
  assign m0.arready = g_arready & ~grant_q;
  assign m1.arready = g_arready &  grant_q;
  assign m0.rvalid  = g_rvalid  & ~grant_q;
  assign m1.rvalid  = g_rvalid  &  grant_q;
  assign m0.rdata   = grant_q ? '0 : g_rdata;
  assign m1.rdata   = grant_q ? g_rdata : '0;
  assign m0.rresp   = grant_q ? '0 : g_rresp;
  assign m1.rresp   = grant_q ? g_rresp : '0;
  assign m0.awready = g_awready & ~grant_q;
  assign m1.awready = g_awready &  grant_q;
  assign m0.wready  = g_wready  & ~grant_q;
  assign m1.wready  = g_wready  &  grant_q;
  assign m0.bvalid  = g_bvalid  & ~grant_q;
  assign m1.bvalid  = g_bvalid  &  grant_q;
  assign m0.bresp   = grant_q ? '0 : g_bresp;
  assign m1.bresp   = grant_q ? g_bresp : '0;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments make every register update from the same pre-edge values.
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // A slave response outside its phase is dropped; flag it in simulation.
  a_rvalid_in_rd_d: assert property (@(posedge clk) disable iff (!rst)
    s.rvalid |-> (state_q == RD_D));
  a_bvalid_in_wr_b: assert property (@(posedge clk) disable iff (!rst)
    s.bvalid |-> (state_q == WR_B));

endmodule
